// File: rtl/sum_sq_accum.sv
// Squares signed vector components and accumulates a saturating 32-bit sum of squares per vector.
// Two-stage pipeline (square, accumulate); result pulses two cycles after in_last; no backpressure.
module sum_sq_accum #(
  parameter int COMP_W  = 16,
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [COMP_W-1:0] in_data,
  input  logic                     in_last,
  output logic [31:0]              data_out,
  output logic                     data_valid,
  output logic                     overflow,
  output logic                     len_err,
  output logic                     busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

  logic [CNT_W-1:0]         cnt;
  logic                     at_max;
  logic                     close_in;
  logic signed [2*COMP_W-1:0] prod;

  logic                     s1_vld;
  logic [2*COMP_W-1:0]      s1_sq;
  logic                     s1_close;
  logic                     s1_len_err;

  logic [31:0]              acc;
  logic                     first;
  logic                     sticky;

  logic [31:0]              base;
  logic [32:0]              sum;
  logic                     sum_ovf;
  logic [31:0]              sum_sat;

  assign at_max   = (cnt == LAST_IDX);
  assign close_in = in_last | at_max;
  assign prod     = in_data * in_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      s1_vld     <= 1'b0;
      s1_sq      <= '0;
      s1_close   <= 1'b0;
      s1_len_err <= 1'b0;
    end else begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_sq      <= $unsigned(prod);
        s1_close   <= close_in;
        s1_len_err <= at_max & ~in_last;
        cnt        <= close_in ? '0 : cnt + 1'b1;
      end
    end
  end

  // A closing element restarts from zero so the next vector never inherits the old sum.
  assign base    = first ? 32'd0 : acc;
  assign sum     = {1'b0, base} + {1'b0, 32'(s1_sq)};
  assign sum_ovf = sum[32];
  assign sum_sat = sum_ovf ? 32'hFFFF_FFFF : sum[31:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      acc        <= '0;
      first      <= 1'b1;
      sticky     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      len_err    <= 1'b0;
      if (s1_vld) begin
        if (s1_close) begin
          data_out   <= sum_sat;
          data_valid <= 1'b1;
          overflow   <= (sticky & ~first) | sum_ovf;
          len_err    <= s1_len_err;
          acc        <= '0;
          first      <= 1'b1;
          sticky     <= 1'b0;
        end else begin
          acc    <= sum_sat;
          first  <= 1'b0;
          sticky <= (sticky & ~first) | sum_ovf;
        end
      end
    end
  end

  assign busy = (cnt != '0) | s1_vld | ~first;

endmodule

// File: tb/tb_sum_sq_accum.sv
// Directed self-checking bench for sum_sq_accum, built with MAX_LEN=4 to reach forced termination.
module tb_sum_sq_accum;

  localparam int COMP_W  = 16;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 3;

  logic                     clock;
  logic                     reset;
  logic                     in_valid;
  logic signed [COMP_W-1:0] in_data;
  logic                     in_last;
  logic [31:0]              data_out;
  logic                     data_valid;
  logic                     overflow;
  logic                     len_err;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  sum_sq_accum #(.COMP_W(COMP_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overflow   (overflow),
    .len_err    (len_err),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one cycle of input, then settle 1 time unit past the capturing edge.
  task automatic drive(input logic v, input logic signed [COMP_W-1:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [31:0] dat,
                         input logic ovf, input logic lerr);
    chk({tag, ".valid"}, 32'(data_valid), 32'(vld));
    if (vld) chk({tag, ".data"}, data_out, dat);
    chk({tag, ".ovf"}, 32'(overflow), 32'(ovf));
    chk({tag, ".len_err"}, 32'(len_err), 32'(lerr));
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst.data_out", data_out, 32'd0);
    chk_out("rst", 1'b0, 32'd0, 1'b0, 1'b0);
    chk("rst.busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Basic 3,4 -> 25, two cycles after in_last
    drive(1'b1, 16'sd3, 1'b0);
    chk("basic.busy", 32'(busy), 32'd1);
    drive(1'b1, 16'sd4, 1'b1);
    chk_out("basic.t1", 1'b0, 32'd0, 1'b0, 1'b0);
    idle();
    chk_out("basic.t2", 1'b1, 32'd25, 1'b0, 1'b0);
    idle();
    chk_out("basic.after", 1'b0, 32'd0, 1'b0, 1'b0);
    chk("basic.hold", data_out, 32'd25);
    chk("basic.busy_end", 32'(busy), 32'd0);

    // Four -32768 saturate
    for (int i = 0; i < 4; i++) drive(1'b1, -16'sd32768, i == 3);
    idle();
    chk_out("sat4", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    // Three -32768 fit; sticky must have been cleared
    for (int i = 0; i < 3; i++) drive(1'b1, -16'sd32768, i == 2);
    chk_out("sat3.pre", 1'b0, 32'd0, 1'b0, 1'b0);
    idle();
    chk_out("sat3", 1'b1, 32'hC000_0000, 1'b0, 1'b0);

    // Back-to-back singles
    drive(1'b1, 16'sd5, 1'b1);
    drive(1'b1, -16'sd7, 1'b1);
    chk_out("b2b.0", 1'b1, 32'd25, 1'b0, 1'b0);
    drive(1'b1, 16'sd0, 1'b1);
    chk_out("b2b.1", 1'b1, 32'd49, 1'b0, 1'b0);
    idle();
    chk_out("b2b.2", 1'b1, 32'd0, 1'b0, 1'b0);
    idle();
    chk_out("b2b.end", 1'b0, 32'd0, 1'b0, 1'b0);

    // Gapped 1,2,2 -> 9
    drive(1'b1, 16'sd1, 1'b0);
    repeat (3) idle();
    chk("gap.busy", 32'(busy), 32'd1);
    drive(1'b1, 16'sd2, 1'b0);
    drive(1'b0, 16'sd9, 1'b1);
    repeat (2) idle();
    chk_out("gap.none", 1'b0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 16'sd2, 1'b1);
    chk_out("gap.t1", 1'b0, 32'd0, 1'b0, 1'b0);
    idle();
    chk_out("gap.t2", 1'b1, 32'd9, 1'b0, 1'b0);

    // Forced termination at MAX_LEN=4
    for (int i = 0; i < 4; i++) drive(1'b1, 16'sd1, 1'b0);
    drive(1'b1, 16'sd1, 1'b0);
    chk_out("force.first", 1'b1, 32'd4, 1'b0, 1'b1);
    drive(1'b1, 16'sd1, 1'b1);
    chk_out("force.mid", 1'b0, 32'd0, 1'b0, 1'b0);
    idle();
    chk_out("force.second", 1'b1, 32'd2, 1'b0, 1'b0);
    idle();

    // Reset mid-vector
    drive(1'b1, 16'sd100, 1'b0);
    drive(1'b1, 16'sd100, 1'b0);
    reset = 1'b1;
    idle();
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk_out("rstmid.out", 1'b0, 32'd0, 1'b0, 1'b0);
    chk("rstmid.data", data_out, 32'd0);
    reset = 1'b0;
    idle();
    chk_out("rstmid.quiet", 1'b0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 16'sd6, 1'b1);
    chk_out("rstmid.t1", 1'b0, 32'd0, 1'b0, 1'b0);
    idle();
    chk_out("rstmid.t2", 1'b1, 32'd36, 1'b0, 1'b0);
    idle();
    chk_out("rstmid.end", 1'b0, 32'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
